// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath/memory bundle for the multi-cycle MIPS controller.
// The controller side is the master; the datapath/memory side is the slave.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [3:0] state_o;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, state_o,
               illegal_op, bus_error
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, state_o,
               illegal_op, bus_error
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with a shared memory port and a
// watchdog that aborts memory accesses that never see mem_ready.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
        MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
        ALUWB  = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state, nxt;
    ctl_t             ctl;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             waiting, done, timeout, bad_op;

    // Per-state select/enable values; registered against the next state so
    // they are glitch-free and line up with the state they belong to.
    function automatic ctl_t state_ctl(state_t s);
        ctl_t c = '0;
        case (s)
            FETCH:          begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:         c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:          begin c.mem_req = 1'b1; c.iord = 1'b1; end
            MEMWR:          begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1; end
            MEMWB:          begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            EXEC:           begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ALUWB:          begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH:         begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; end
            JUMP:           c.pc_src = 2'b10;
            ADDIWB:         c.reg_write = 1'b1;
            default:        ;
        endcase
        return c;
    endfunction

    // Watchdog and handshake qualifiers key off the registered mem_req, so a
    // stray mem_ready outside an outstanding access has no effect.
    always_comb begin
        waiting = ctl.mem_req && !bus.mem_ready;
        done    = ctl.mem_req &&  bus.mem_ready;
        timeout = waiting && (cnt == CNT_W'(TIMEOUT - 1));
        bad_op  = 1'b0;
        nxt     = state;
        case (state)
            IDLE:   nxt = FETCH;
            FETCH:  if (done) nxt = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDIEX;
                    default: begin
                        nxt    = FETCH;
                        bad_op = 1'b1;
                    end
                endcase
            end
            MEMADR: nxt = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (done) nxt = MEMWB;
            MEMWR:  if (done) nxt = FETCH;
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: nxt = FETCH;
            default: nxt = IDLE;
        endcase
        if (timeout) nxt = FETCH;
        cnt_nxt = (waiting && !timeout) ? cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            ctl   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            ctl   <= state_ctl(nxt);
            // After an abort, FETCH spends one cycle with the request dropped.
            if (timeout) ctl.mem_req <= 1'b0;
        end
    end

    assign bus.mem_req    = ctl.mem_req;
    assign bus.mem_we     = ctl.mem_we;
    assign bus.iord       = ctl.iord;
    assign bus.pc_src     = ctl.pc_src;
    assign bus.alu_src_a  = ctl.alu_src_a;
    assign bus.alu_src_b  = ctl.alu_src_b;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.reg_dst    = ctl.reg_dst;
    assign bus.mem_to_reg = ctl.mem_to_reg;
    assign bus.reg_write  = ctl.reg_write;
    assign bus.ir_write   = (state == FETCH) && done;
    assign bus.pc_write   = ((state == FETCH) && done) || (state == JUMP) ||
                            ((state == BRANCH) && bus.zero);
    assign bus.state_o    = state;
    assign bus.illegal_op = bad_op;
    assign bus.bus_error  = timeout;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class,
// the watchdog abort, and an asynchronous reset in the middle of an access.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_we,iord,ir_write,pc_write,pc_src,alu_src_a,alu_src_b,alu_op,
    //  reg_dst,mem_to_reg,reg_write,illegal_op,bus_error}
    logic [16:0] outs;
    assign outs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                   bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal_op,
                   bus.bus_error};

    localparam logic [16:0] Z       = 17'b0_0_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] F_WAIT  = 17'b1_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [16:0] F_RDY   = 17'b1_0_0_1_1_00_0_01_00_0_0_0_0_0;
    localparam logic [16:0] F_GAP   = 17'b0_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [16:0] DEC     = 17'b0_0_0_0_0_00_0_11_00_0_0_0_0_0;
    localparam logic [16:0] DEC_ILL = 17'b0_0_0_0_0_00_0_11_00_0_0_0_1_0;
    localparam logic [16:0] EXE     = 17'b0_0_0_0_0_00_1_00_10_0_0_0_0_0;
    localparam logic [16:0] AWB     = 17'b0_0_0_0_0_00_0_00_00_1_0_1_0_0;
    localparam logic [16:0] MADR    = 17'b0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [16:0] MRD     = 17'b1_0_1_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] MWB     = 17'b0_0_0_0_0_00_0_00_00_0_1_1_0_0;
    localparam logic [16:0] MWR     = 17'b1_1_1_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] MWR_TO  = 17'b1_1_1_0_0_00_0_00_00_0_0_0_0_1;
    localparam logic [16:0] BR1     = 17'b0_0_0_0_1_01_1_00_01_0_0_0_0_0;
    localparam logic [16:0] BR0     = 17'b0_0_0_0_0_01_1_00_01_0_0_0_0_0;
    localparam logic [16:0] JMP     = 17'b0_0_0_0_1_10_0_00_00_0_0_0_0_0;
    localparam logic [16:0] IWB     = 17'b0_0_0_0_0_00_0_00_00_0_0_1_0_0;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check state and outputs, then advance a clock.
    task automatic cyc(input logic rdy, input logic z, input logic [5:0] op,
                       input string tag, input logic [3:0] st, input logic [16:0] eo);
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = op;
        #1;
        chk({tag, ".state"}, 17'(bus.state_o), 17'(st));
        chk({tag, ".outs"}, outs, eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.opcode    = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state", 17'(bus.state_o), 17'd0);
        chk("reset.outs", outs, Z);
        reset = 1'b1;
        cyc(0, 0, 6'b000000, "idle", 4'd0, Z);

        // add with memory always ready: 4 cycles
        cyc(1, 0, 6'b000000, "add_f",  4'd1, F_RDY);
        cyc(1, 0, 6'b000000, "add_d",  4'd2, DEC);
        cyc(1, 0, 6'b000000, "add_x",  4'd7, EXE);
        cyc(1, 0, 6'b000000, "add_wb", 4'd8, AWB);

        // lw, ready on the 3rd cycle of each access; ready in MEMADR ignored
        cyc(0, 0, 6'b100011, "lw_f0", 4'd1, F_WAIT);
        cyc(0, 0, 6'b100011, "lw_f1", 4'd1, F_WAIT);
        cyc(1, 0, 6'b100011, "lw_f2", 4'd1, F_RDY);
        cyc(0, 0, 6'b100011, "lw_d",  4'd2, DEC);
        cyc(1, 0, 6'b100011, "lw_a",  4'd3, MADR);
        cyc(0, 0, 6'b100011, "lw_r0", 4'd4, MRD);
        cyc(0, 0, 6'b100011, "lw_r1", 4'd4, MRD);
        cyc(1, 0, 6'b100011, "lw_r2", 4'd4, MRD);
        cyc(0, 0, 6'b100011, "lw_wb", 4'd5, MWB);

        // beq taken then not taken
        cyc(1, 0, 6'b000100, "beq1_f", 4'd1, F_RDY);
        cyc(1, 0, 6'b000100, "beq1_d", 4'd2, DEC);
        cyc(1, 1, 6'b000100, "beq1_b", 4'd9, BR1);
        cyc(1, 0, 6'b000100, "beq0_f", 4'd1, F_RDY);
        cyc(1, 0, 6'b000100, "beq0_d", 4'd2, DEC);
        cyc(1, 0, 6'b000100, "beq0_b", 4'd9, BR0);

        // illegal opcode
        cyc(1, 0, 6'b111111, "ill_f",    4'd1, F_RDY);
        cyc(1, 0, 6'b111111, "ill_d",    4'd2, DEC_ILL);
        cyc(0, 0, 6'b111111, "ill_next", 4'd1, F_WAIT);

        // jump and addi
        cyc(1, 0, 6'b000010, "j_f",     4'd1,  F_RDY);
        cyc(1, 0, 6'b000010, "j_d",     4'd2,  DEC);
        cyc(1, 0, 6'b000010, "j_j",     4'd10, JMP);
        cyc(1, 0, 6'b001000, "addi_f",  4'd1,  F_RDY);
        cyc(1, 0, 6'b001000, "addi_d",  4'd2,  DEC);
        cyc(1, 0, 6'b001000, "addi_x",  4'd11, MADR);
        cyc(1, 0, 6'b001000, "addi_wb", 4'd12, IWB);

        // sw with memory hung: abort on the 4th wait cycle
        cyc(1, 0, 6'b101011, "sw_f",   4'd1, F_RDY);
        cyc(1, 0, 6'b101011, "sw_d",   4'd2, DEC);
        cyc(0, 0, 6'b101011, "sw_a",   4'd3, MADR);
        cyc(0, 0, 6'b101011, "sw_w0",  4'd6, MWR);
        cyc(0, 0, 6'b101011, "sw_w1",  4'd6, MWR);
        cyc(0, 0, 6'b101011, "sw_w2",  4'd6, MWR);
        cyc(0, 0, 6'b101011, "sw_to",  4'd6, MWR_TO);
        cyc(0, 0, 6'b101011, "sw_gap", 4'd1, F_GAP);

        // ready arriving on the timeout cycle completes normally
        cyc(0, 0, 6'b100011, "tw_f0", 4'd1, F_WAIT);
        cyc(0, 0, 6'b100011, "tw_f1", 4'd1, F_WAIT);
        cyc(0, 0, 6'b100011, "tw_f2", 4'd1, F_WAIT);
        cyc(1, 0, 6'b100011, "tw_f3", 4'd1, F_RDY);
        cyc(0, 0, 6'b100011, "tw_d",  4'd2, DEC);
        cyc(0, 0, 6'b100011, "tw_a",  4'd3, MADR);
        cyc(0, 0, 6'b100011, "tw_r0", 4'd4, MRD);

        // asynchronous reset while waiting in MEMRD
        #2;
        reset = 1'b0;
        #1;
        chk("arst.state", 17'(bus.state_o), 17'd0);
        chk("arst.outs", outs, Z);
        @(posedge clk);
        #1;
        chk("arst_hold.state", 17'(bus.state_o), 17'd0);
        reset = 1'b1;
        cyc(0, 0, 6'b100011, "rel_idle", 4'd0, Z);
        cyc(0, 0, 6'b100011, "rel_f",    4'd1, F_WAIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
